// File: rtl/hex_counter_pkg.sv
// Shared definitions for the hex rate counter: speed encodings and divider sizing helpers.
package hex_counter_pkg;

    typedef enum logic [1:0] {
        SPEED_FULL       = 2'b00,
        SPEED_1HZ        = 2'b01,
        SPEED_HALF_HZ    = 2'b10,
        SPEED_QUARTER_HZ = 2'b11
    } speed_e;

    // Wide enough to hold the slowest reload value, 4*clk_hz-1.
    function automatic int unsigned div_width(input int unsigned clk_hz);
        return $clog2(4 * clk_hz);
    endfunction

    function automatic int unsigned reload_value(input logic [1:0] speed,
                                                 input int unsigned clk_hz);
        int unsigned r;
        r = 0;
        unique case (speed)
            SPEED_FULL:       r = 0;
            SPEED_1HZ:        r = clk_hz - 1;
            SPEED_HALF_HZ:    r = 2 * clk_hz - 1;
            SPEED_QUARTER_HZ: r = 4 * clk_hz - 1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hex_digit_counter.sv
// One hex digit of the chained counter; carry_o flags that this and all lower digits are at
// their rollover value for the current direction.
module hex_digit_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       step_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [3:0] load_nibble_i,
    input  logic       carry_i,
    output logic       carry_o,
    output logic [3:0] nibble_o
);

    logic [3:0] nibble_d, nibble_q;

    always_comb begin
        nibble_d = nibble_q;
        if (load_i) begin
            nibble_d = load_nibble_i;
        end else if (step_i && carry_i) begin
            nibble_d = up_i ? (nibble_q + 4'd1) : (nibble_q - 4'd1);
        end
    end

    assign carry_o  = carry_i & (up_i ? (nibble_q == 4'hF) : (nibble_q == 4'h0));
    assign nibble_o = nibble_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nibble_q <= 4'h0;
        end else begin
            nibble_q <= nibble_d;
        end
    end

endmodule

// File: rtl/hex_rate_counter.sv
// Multi-digit hex counter stepped by a selectable-rate divider, with registered tick/wrap
// pulses for chaining.
module hex_rate_counter
    import hex_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [1:0]            speed,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  wrap
);

    localparam int unsigned DivW = div_width(CLK_HZ);

    logic [DivW-1:0] div_d, div_q;
    logic [DivW-1:0] div_eff;
    logic [DivW-1:0] reload_cur;
    logic [1:0]      speed_d, speed_q;
    logic            tick_d, tick_q;
    logic            wrap_d, wrap_q;
    logic            init_d, init_q;
    logic            speed_chg;
    logic            step;
    logic [DIGITS:0] carry;

    assign reload_cur = DivW'(reload_value(speed, CLK_HZ));

    // On the first edge after reset the divider behaves as if it had been loaded with
    // reload(speed) at release, and the speed history is not yet meaningful.
    assign div_eff   = init_q ? reload_cur : div_q;
    assign speed_chg = !init_q && (speed != speed_q);

    always_comb begin
        div_d   = div_eff;
        speed_d = speed;
        init_d  = 1'b0;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        step    = 1'b0;
        if (load) begin
            div_d = reload_cur;
        end else if (speed_chg) begin
            div_d = reload_cur;
        end else if (enable) begin
            if (div_eff == '0) begin
                step   = 1'b1;
                div_d  = reload_cur;
                tick_d = 1'b1;
                wrap_d = carry[DIGITS];
            end else begin
                div_d = div_eff - DivW'(1);
            end
        end
    end

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        hex_digit_counter u_digit (
            .clk_i        (CLOCK_50),
            .rst_ni       (resetn),
            .step_i       (step),
            .up_i         (up),
            .load_i       (load),
            .load_nibble_i(load_value[4*g +: 4]),
            .carry_i      (carry[g]),
            .carry_o      (carry[g+1]),
            .nibble_o     (count[4*g +: 4])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_q   <= '0;
            speed_q <= 2'b00;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            div_q   <= div_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            init_q  <= init_d;
        end
    end

    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter at CLK_HZ=4; inputs change and outputs are sampled on
// the falling clock edge.
module tb_hex_rate_counter;

    logic        CLOCK_50;
    logic        resetn;
    logic        enable;
    logic [1:0]  speed;
    logic        up;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count;
    logic        tick;
    logic        wrap;

    int n_vec;
    int n_err;

    hex_rate_counter #(
        .CLK_HZ(4),
        .DIGITS(4)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .enable    (enable),
        .speed     (speed),
        .up        (up),
        .load      (load),
        .load_value(load_value),
        .count     (count),
        .tick      (tick),
        .wrap      (wrap)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, returning on a falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk3(input string tag, input logic [15:0] c, input logic t, input logic w);
        chk({tag, ".count"}, {16'h0, count}, {16'h0, c});
        chk({tag, ".tick"}, {31'h0, tick}, {31'h0, t});
        chk({tag, ".wrap"}, {31'h0, wrap}, {31'h0, w});
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        enable     = 1'b1;
        speed      = 2'b01;
        up         = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;
        cyc(2);
        chk3("reset", 16'h0000, 1'b0, 1'b0);
        resetn = 1'b1;

        // Speed 01: period 4 cycles from release.
        cyc(3);
        chk3("s1_pre1", 16'h0000, 1'b0, 1'b0);
        cyc(1);
        chk3("s1_step1", 16'h0001, 1'b1, 1'b0);
        cyc(1);
        chk3("s1_after1", 16'h0001, 1'b0, 1'b0);
        cyc(2);
        chk("s1_pre2", {16'h0, count}, 32'h0001);
        cyc(1);
        chk3("s1_step2", 16'h0002, 1'b1, 1'b0);

        // Load near the top, count up at full speed across the wrap.
        load = 1'b1; load_value = 16'hFFFE; speed = 2'b00;
        cyc(1);
        chk3("ld_fffe", 16'hFFFE, 1'b0, 1'b0);
        load = 1'b0;
        cyc(1);
        chk3("up_ffff", 16'hFFFF, 1'b1, 1'b0);
        cyc(1);
        chk3("up_wrap", 16'h0000, 1'b1, 1'b1);
        cyc(1);
        chk3("up_0001", 16'h0001, 1'b1, 1'b0);

        // Down count: borrow across two digits, then wrap below zero.
        load = 1'b1; load_value = 16'h0100; up = 1'b0;
        cyc(1);
        chk3("ld_0100", 16'h0100, 1'b0, 1'b0);
        load = 1'b0;
        cyc(1);
        chk3("dn_00ff", 16'h00FF, 1'b1, 1'b0);
        load = 1'b1; load_value = 16'h0000;
        cyc(1);
        chk3("ld_0000", 16'h0000, 1'b0, 1'b0);
        load = 1'b0;
        cyc(1);
        chk3("dn_wrap", 16'hFFFF, 1'b1, 1'b1);

        // Speed 11: pause mid-period keeps the remaining 6 cycles.
        load = 1'b1; load_value = 16'h0010; speed = 2'b11; up = 1'b1;
        cyc(1);
        chk3("ld_0010", 16'h0010, 1'b0, 1'b0);
        load = 1'b0;
        cyc(10);
        chk3("q_run10", 16'h0010, 1'b0, 1'b0);
        enable = 1'b0;
        cyc(20);
        chk3("q_paused", 16'h0010, 1'b0, 1'b0);
        enable = 1'b1;
        cyc(5);
        chk3("q_resume5", 16'h0010, 1'b0, 1'b0);
        cyc(1);
        chk3("q_step", 16'h0011, 1'b1, 1'b0);

        // Speed 10 then switch to 01 mid-period: restart at the 4-cycle period.
        speed = 2'b10;
        cyc(1);
        chk3("h_switch", 16'h0011, 1'b0, 1'b0);
        cyc(3);
        speed = 2'b01;
        cyc(1);
        chk3("sw_edge", 16'h0011, 1'b0, 1'b0);
        cyc(3);
        chk3("sw_pre", 16'h0011, 1'b0, 1'b0);
        cyc(1);
        chk3("sw_step", 16'h0012, 1'b1, 1'b0);

        // Load coincident with a full-speed step condition.
        speed = 2'b00;
        cyc(1);
        chk3("f_switch", 16'h0012, 1'b0, 1'b0);
        load = 1'b1; load_value = 16'h1233;
        cyc(1);
        chk3("ld_vs_step", 16'h1233, 1'b0, 1'b0);
        load = 1'b0;
        cyc(1);
        chk3("f_1234", 16'h1234, 1'b1, 1'b0);

        // Asynchronous reset between edges clears count and tick at once.
        #2;
        resetn = 1'b0;
        #1;
        chk3("async_rst", 16'h0000, 1'b0, 1'b0);
        @(negedge CLOCK_50);
        chk3("rst_hold", 16'h0000, 1'b0, 1'b0);
        resetn = 1'b1;
        cyc(1);
        chk3("rel_full", 16'h0001, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hex_rate_counter.md
# hex_rate_counter

Free-running four-digit hexadecimal counter with selectable count rate, direction, parallel load and pause, producing the nibbles that the board's 7-segment HEX decoders display. It sits directly upstream of the per-digit HEX decoders: nibble *i* of `count` drives the decoder for HEX*i*. The count rate is derived from the 50 MHz board clock by an internal rate divider. Registered `tick` and `wrap` pulses are exported for chaining to further displays or LEDs.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency; sets the divider reload values. Benches use 4.
- `DIGITS`, 4: number of hex digits; `count` width is 4*DIGITS.
- `CLOCK_50`  in  1  system clock, rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run, 0 = pause (divider and count hold).
- `speed`  in  2  rate select: 00 every cycle, 01 1 Hz, 10 0.5 Hz, 11 0.25 Hz.
- `up`  in  1  1 = increment, 0 = decrement.
- `load`  in  1  synchronous parallel load strobe.
- `load_value`  in  4*DIGITS  value taken on `load`.
- `count`  out  4*DIGITS  current count; nibble i → HEX*i* decoder.
- `tick`  out  1  one-cycle pulse: `count` changed on this edge.
- `wrap`  out  1  one-cycle pulse with `tick` when count wrapped (all-F→0 up, 0→all-F down).

## Operation
- Reset (async, `resetn`=0): `count`=0, divider=reload(`speed`) sampled at release, `tick`=0, `wrap`=0, `speed` history register = 0.
- Divider: down-counter `div`, width ceil(log2(4*CLK_HZ)). Reload values: 00→0, 01→CLK_HZ-1, 10→2*CLK_HZ-1, 11→4*CLK_HZ-1.
- Priority per edge: reset > `load` > `speed` change > count step.
- `load`=1: `count`←`load_value`, `div`←reload(`speed`), `tick`=`wrap`=0. Applies regardless of `enable`.
- `speed` differs from previous cycle's registered value: `div`←reload(new `speed`), no step that cycle.
- `enable`=1, `div`≠0: `div`←`div`-1.
- `enable`=1, `div`=0: step `count` by ±1 (mod 16^DIGITS), `div`←reload(`speed`), `tick`←1, `wrap`←1 iff step wrapped.
- `enable`=0: `div`, `count` hold; `tick`=`wrap`=0.
- Digit chain: digit 0 steps on every step; digit i steps when all lower digits are F (up) or 0 (down). Carry/borrow is combinational through the chain, single-cycle.

## Timing
- `tick`, `wrap` are registered: high in the same cycle the new `count` is first visible, low the next cycle unless another step occurs.
- Speed 00: step every enabled cycle; `tick` held high continuously.
- Speed 01/10/11: step period exactly CLK_HZ, 2*CLK_HZ, 4*CLK_HZ enabled cycles.
- First step after reset release or load: reload+1 enabled cycles later.
- Pausing mid-period and resuming: remaining period is preserved (no restart).
- `up` changed mid-period: takes effect at next step; period not restarted.
- `load` and step condition in same cycle: load wins, no `tick`.
- Reset asserted mid-period: all state cleared immediately, no glitch pulse on `tick`.

## Structure
- Package `hex_counter_pkg`: speed encodings (`SPEED_FULL`, `SPEED_1HZ`, `SPEED_HALF_HZ`, `SPEED_QUARTER_HZ`), reload function of (`speed`, `CLK_HZ`), divider width function.
- Sub-module `hex_digit_counter`: one 4-bit digit with `step`, `up`, `load`, `load_nibble`, carry-in and carry-out (all-F/all-0 detect); instantiated DIGITS times in a generate loop. Divider and pulse logic live in the top.

## Test plan (CLK_HZ=4)
- Reset, `enable`=1, `speed`=01, `up`=1 → `count`=0x0001 after 4 cycles, 0x0002 after 8; `tick` high one cycle each step.
- `load`=1 with `load_value`=0xFFFE, speed 00, up → 0xFFFF, then 0x0000 with `wrap`=1 in that cycle only, then 0x0001.
- `load_value`=0x0100, `up`=0, speed 00 → 0x00FF (borrow across two digits); then load 0x0000, one step → 0xFFFF with `wrap`=1.
- Speed 11, drop `enable` after 10 cycles for 20 cycles, re-enable → step 6 enabled cycles later; `count` unchanged while paused.
- Speed 10, switch to 01 mid-period → no step that cycle; next step exactly 4 cycles after the switch.
- Assert `resetn`=0 asynchronously between edges with `count`=0x1234 → `count`=0, `tick`=0 immediately; `load` coincident with step condition → `load_value` taken, no `tick`.
